// File: rtl/fu_sequencer_pkg.sv
// Shared definitions for the FU issuing sequencer: FU opcodes, status flag
// bit positions and the sequencer state encoding.
package fu_sequencer_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    // MUL8 occupies the whole 10xx group; this is its base code.
    localparam logic [3:0] OP_MUL8 = 4'b1000;
    localparam logic [3:0] OP_LSL  = 4'b1100;
    localparam logic [3:0] OP_LSR  = 4'b1101;
    localparam logic [3:0] OP_ASL  = 4'b1110;
    localparam logic [3:0] OP_ASR  = 4'b1111;

    localparam int ST_N = 0;
    localparam int ST_Z = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/fu_sequencer.sv
// Issues commands to the 16-bit FU, returns responses, owns the PSR, and
// sequences MUL16 as WIDTH shift-add iterations through the FU ADD path.
module fu_sequencer
    import fu_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_mul16,
    input  logic             cmd_setcc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [3:0]       fu_opcode,
    input  logic [WIDTH-1:0] fu_result,
    input  logic [3:0]       fu_status,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [3:0]       psr
);

    localparam int CNT_W = $clog2(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; once raised, rsp_valid and the response hold until then.
    state_t           state, next_state;
    logic             accept;
    logic             setcc_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic             mul_last;
    logic [3:0]       mul_psr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = cmd_mul16 ? S_MUL : S_EXEC;
            end
            S_EXEC: next_state = S_RESP;
            S_MUL:  if (mul_last) next_state = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));

    // One shift-add step: {carry, sum, lo} shifted right by one.
    assign hi_nx = {fu_status[ST_C], fu_result[WIDTH-1:1]};
    assign lo_nx = {fu_result[0], lo_q[WIDTH-1:1]};

    always_comb begin
        mul_psr       = '0;
        mul_psr[ST_N] = hi_nx[WIDTH-1];
        mul_psr[ST_Z] = ({hi_nx, lo_nx} == '0);
        mul_psr[ST_V] = (hi_nx != '0);
    end

    // fu_* are registered so they hold their last driven value in IDLE/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_a       <= '0;
            fu_b       <= '0;
            fu_opcode  <= OP_AND;
            rsp_result <= '0;
            rsp_hi     <= '0;
            psr        <= '0;
            setcc_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            m_q        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    setcc_q <= cmd_setcc;
                    if (cmd_mul16) begin
                        hi_q      <= '0;
                        lo_q      <= cmd_b;
                        m_q       <= cmd_a;
                        cnt       <= '0;
                        fu_a      <= '0;
                        fu_b      <= cmd_b[0] ? cmd_a : '0;
                        fu_opcode <= OP_ADD;
                    end else begin
                        fu_a      <= cmd_a;
                        fu_b      <= cmd_b;
                        fu_opcode <= cmd_op;
                    end
                end
                S_EXEC: begin
                    rsp_result <= fu_result;
                    rsp_hi     <= '0;
                    if (setcc_q) psr <= fu_status;
                end
                S_MUL: begin
                    hi_q <= hi_nx;
                    lo_q <= lo_nx;
                    cnt  <= cnt + 1'b1;
                    if (mul_last) begin
                        rsp_hi     <= hi_nx;
                        rsp_result <= lo_nx;
                        if (setcc_q) psr <= mul_psr;
                    end else begin
                        fu_a <= hi_nx;
                        fu_b <= lo_nx[0] ? m_q : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer with a behavioural 16-bit FU beside it.
module tb_fu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic        cmd_mul16, cmd_setcc;
    logic [15:0] cmd_a, cmd_b;
    logic [15:0] fu_a, fu_b;
    logic [3:0]  fu_opcode;
    logic [15:0] fu_result;
    logic [3:0]  fu_status;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result, rsp_hi;
    logic [3:0]  psr;

    int total = 0;
    int bad   = 0;

    fu_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mul16(cmd_mul16), .cmd_setcc(cmd_setcc), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fu_a(fu_a), .fu_b(fu_b), .fu_opcode(fu_opcode),
        .fu_result(fu_result), .fu_status(fu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_hi(rsp_hi), .psr(psr)
    );

    always #5 clk = ~clk;

    // Behavioural FU: combinational result and {V,C,Z,N} flags.
    logic [16:0] fu_sum;
    logic        fu_c, fu_v;
    always_comb begin
        fu_sum    = '0;
        fu_c      = 1'b0;
        fu_v      = 1'b0;
        fu_result = fu_a;
        case (fu_opcode)
            4'b0000: fu_result = fu_a & fu_b;
            4'b0001: fu_result = fu_a | fu_b;
            4'b0010: fu_result = ~fu_a;
            4'b0011: fu_result = fu_a ^ fu_b;
            4'b0100: begin
                fu_sum    = {1'b0, fu_a} + {1'b0, fu_b};
                fu_result = fu_sum[15:0];
                fu_c      = fu_sum[16];
                fu_v      = (fu_a[15] == fu_b[15]) && (fu_result[15] != fu_a[15]);
            end
            4'b0101: begin
                fu_sum    = {1'b0, fu_a} + {1'b0, ~fu_b} + 17'd1;
                fu_result = fu_sum[15:0];
                fu_c      = fu_sum[16];
                fu_v      = (fu_a[15] != fu_b[15]) && (fu_result[15] != fu_a[15]);
            end
            default: ;
        endcase
        fu_status = {fu_v, fu_c, (fu_result == 16'h0000), fu_result[15]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one command and returns once the handshake edge has passed (#1 after it).
    task automatic issue(input logic [3:0] op, input logic mul, input logic setcc,
                         input logic [15:0] a, input logic [15:0] b, input string tag);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mul16 = mul;
        cmd_setcc = setcc;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic mul, input logic setcc,
                           input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                           input logic [15:0] exp_res, input logic [15:0] exp_hi,
                           input logic [3:0] exp_psr, input string tag);
        int lat = 0;
        issue(op, mul, setcc, a, b, tag);
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, {16'h0, rsp_result}, {16'h0, exp_res});
        check({tag, "_hi"}, {16'h0, rsp_hi}, {16'h0, exp_hi});
        check({tag, "_psr"}, {28'h0, psr}, {28'h0, exp_psr});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_mul16 = 1'b0;
        cmd_setcc = 1'b0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", {16'h0, rsp_result}, 32'h0);
        check("rst_rsp_hi", {16'h0, rsp_hi}, 32'h0);
        check("rst_psr", {28'h0, psr}, 32'h0);
        check("rst_fu_a", {16'h0, fu_a}, 32'h0);
        check("rst_fu_b", {16'h0, fu_b}, 32'h0);
        check("rst_fu_opcode", {28'h0, fu_opcode}, 32'h0);

        // Single-cycle ops
        run_cmd(4'b0100, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000, 4'b0110, "add_carry");
        check("add_fu_opcode", {28'h0, fu_opcode}, 32'h4);
        run_cmd(4'b0100, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 4'b1001, "add_ovf");
        run_cmd(4'b0000, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 1, 16'h3030, 16'h0000, 4'b1001, "and_nocc");
        check("and_fu_a_hold", {16'h0, fu_a}, 32'hF0F0);

        // MUL16
        run_cmd(4'b0000, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 16'hFFFE, 4'b1001, "mul_max");
        run_cmd(4'b1111, 1'b1, 1'b1, 16'h0003, 16'h0005, 16, 16'h000F, 16'h0000, 4'b0000, "mul_small");

        // Backpressure with a second command held on cmd_valid
        issue(4'b0011, 1'b0, 1'b1, 16'h8234, 16'h00FF, "bp");
        cmd_valid = 1'b1;
        cmd_op    = 4'b0100;
        cmd_setcc = 1'b0;
        cmd_a     = 16'h0002;
        cmd_b     = 16'h0003;
        @(posedge clk);
        #1;
        check("bp_first_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 32'(rsp_valid), 32'd1);
            check("bp_result_held", {16'h0, rsp_result}, 32'h82CB);
            check("bp_no_accept", 32'(cmd_ready), 32'd0);
        end
        check("bp_psr", {28'h0, psr}, 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_handshake_drop", 32'(rsp_valid), 32'd0);
        check("bp_idle_after_hs", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_held_accepted", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check("bp_held_valid", 32'(rsp_valid), 32'd1);
        check("bp_held_result", {16'h0, rsp_result}, 32'h0005);
        check("bp_held_psr", {28'h0, psr}, 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset in the middle of a MUL16
        issue(4'b0000, 1'b1, 1'b1, 16'h1234, 16'h5678, "mul_abort");
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_psr", {28'h0, psr}, 32'h0);
        check("abort_fu_a", {16'h0, fu_a}, 32'h0);
        check("abort_rsp_hi", {16'h0, rsp_hi}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        run_cmd(4'b0000, 1'b1, 1'b1, 16'h0100, 16'h0100, 16, 16'h0000, 16'h0001, 4'b1000, "mul_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
